// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit handing words and their PCs to the decoder.
// Optional build macro IFU_PERF_EN adds decoder handshake / stall performance counters.
module ifu_fetch #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    // state | meaning
    // IDLE  | first cycle out of reset
    // REQ   | request presented to instruction memory
    // WAIT  | request accepted, awaiting the response
    // HOLD  | instruction presented to the decoder
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid) pc_d = redir_pc;
                if (imem_req_ready) begin
                    state_d = WAIT;
                    // an accepted request to the stale PC must be discarded when it returns
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                    end else if (!drop_q) begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redir_pc;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (inst_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        req_valid_d  = (state_d == REQ);
        inst_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (inst_valid_q && inst_ready)  perf_fetch_q <= perf_fetch_q + 64'd1;
            if (inst_valid_q && !inst_ready) perf_stall_q <= perf_stall_q + 64'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios with a scoreboard of expected decoder words.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic accept_req();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
    endtask

    task automatic send_resp(input logic [31:0] d);
        imem_resp_valid = 1'b1;
        imem_resp_data = d;
        cyc();
        imem_resp_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (imem_req_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: imem_req_valid=%b required 1", name, imem_req_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            inst_pc !== 64'h0 || imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL reset_values: req_v=%b inst_v=%b inst=%h inst_pc=%h addr=%h required 0 0 0 0 80000000",
                     imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf: fetch=%0d stall=%0d required 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        rst = 1'b0;
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL first_req: req_v=%b addr=%h required 1 80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_basic_fetch();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        checks++;
        if (imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL basic_addr: got %h required 80000000", imem_req_addr);
        end
        sb.push_back('{data: 32'h0010_0513, pc: 64'h8000_0000});
        accept_req();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait: req_v=%b inst_v=%b required 0 0", imem_req_valid, inst_valid);
        end
        send_resp(32'h0010_0513);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL basic_inst: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_next: req_v=%b addr=%h inst_v=%b required 1 80000004 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        sb.push_back('{data: 32'h0020_0593, pc: 64'h8000_0000});
        accept_req();
        send_resp(32'h0020_0593);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL stall_inst: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b inst=%h pc=%h req_v=%b required 1 %h %h 0",
                         i, inst_valid, inst, inst_pc, imem_req_valid, e.data, e.pc);
            end
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_stall_cnt !== 64'd5 || perf_fetch_cnt !== 64'd0) begin
            errors++;
            $display("FAIL stall_perf: stall=%0d fetch=%0d required 5 0", perf_stall_cnt, perf_fetch_cnt);
        end
`endif
        inst_ready = 1'b1;
        cyc();
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin
            errors++;
            $display("FAIL stall_release: inst_v=%b req_v=%b addr=%h required 0 1 80000004",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_stall_cnt !== 64'd5 || perf_fetch_cnt !== 64'd1) begin
            errors++;
            $display("FAIL stall_perf_done: stall=%0d fetch=%0d required 5 1", perf_stall_cnt, perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_redirect_wait();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        accept_req();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0103;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_wait: req_v=%b inst_v=%b required 0 0", imem_req_valid, inst_valid);
        end
        send_resp(32'hDEAD_BEEF);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
            errors++;
            $display("FAIL rw_drop: inst_v=%b req_v=%b addr=%h required 0 1 80000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        sb.push_back('{data: 32'h1234_5678, pc: 64'h8000_0100});
        accept_req();
        send_resp(32'h1234_5678);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL rw_after: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
        cyc();
        accept_req();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0302;
        send_resp(32'hBAD0_BAD0);
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin
            errors++;
            $display("FAIL rw_same_cycle: inst_v=%b req_v=%b addr=%h required 0 1 80000300",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_req();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0044;
        imem_req_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_accept: req_v=%b required 0", imem_req_valid);
        end
        send_resp(32'h1111_1111);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0044) begin
            errors++;
            $display("FAIL rr_drop: inst_v=%b req_v=%b addr=%h required 0 1 80000044",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        sb.push_back('{data: 32'h2222_2222, pc: 64'h8000_0044});
        accept_req();
        send_resp(32'h2222_2222);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL rr_after: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
    endtask

    task automatic test_redirect_hold();
        exp_t e;
        do_reset();
        sb.push_back('{data: 32'h0030_0613, pc: 64'h8000_0000});
        accept_req();
        send_resp(32'h0030_0613);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL rh_inst: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
            errors++;
            $display("FAIL rh_redirect: inst_v=%b req_v=%b addr=%h required 0 1 80000200",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 64'd0 || perf_stall_cnt !== 64'd1) begin
            errors++;
            $display("FAIL rh_perf: fetch=%0d stall=%0d required 0 1", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: req_v=%b addr=%h required 1 80000000", i, imem_req_valid, imem_req_addr);
            end
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hAAAA_AAAA;
        cyc();
        imem_resp_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL bp_stray_req: req_v=%b inst_v=%b addr=%h required 1 0 80000000",
                     imem_req_valid, inst_valid, imem_req_addr);
        end
        accept_req();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h5555_5555;
        cyc();
        imem_resp_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL bp_reset_restart: req_v=%b inst_v=%b addr=%h required 1 0 80000000",
                     imem_req_valid, inst_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_redirect: req_v=%b addr=%h required 1 fffffffffffffffc", imem_req_valid, imem_req_addr);
        end
        sb.push_back('{data: 32'h0000_0013, pc: 64'hFFFF_FFFF_FFFF_FFFC});
        accept_req();
        send_resp(32'h0000_0013);
        e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL wrap_inst: v=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc);
        end
        cyc();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap_next: req_v=%b addr=%h required 1 0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [63:0] exp_pc = 64'h8000_0000;
        logic [31:0] d;
        int          lat;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_req("b2b_req");
            checks++;
            if (imem_req_addr !== exp_pc) begin
                errors++;
                $display("FAIL b2b_addr[%0d]: got %h required %h", i, imem_req_addr, exp_pc);
            end
            d = $urandom;
            lat = $urandom_range(1, 3);
            sb.push_back('{data: d, pc: exp_pc});
            accept_req();
            repeat (lat - 1) cyc();
            send_resp(d);
            e = sb.pop_front();
            checks++;
            if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc) begin
                errors++;
                $display("FAIL b2b_inst[%0d]: v=%b inst=%h pc=%h required 1 %h %h",
                         i, inst_valid, inst, inst_pc, e.data, e.pc);
            end
            exp_pc = exp_pc + 64'd4;
            cyc();
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 64'd8 || perf_stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL b2b_perf: fetch=%0d stall=%0d required 8 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_hold();
        test_backpressure_reset();
        test_wrap();
        test_back_to_back();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
